// File: rtl/master_interconnect.sv
// master_interconnect
//   Master-side stage of the crossbar. Accepts one Avalon-MM master, decodes
//   the target slave from the top address bits, requests that slave's arbiter
//   (Req/Lock/Gnt) and forwards the transfer once granted. Accesses whose
//   address does not map to a slave complete locally, returning DECERR_DATA.
//
// Optional build macro: MASTER_INTERCONNECT_TIMEOUT_EN
//   Defined   : a watchdog aborts ARB/XFER after TIMEOUT_CYCLES cycles, pulses
//               o_Timeout and finishes the access with DECERR_DATA.
//   Undefined : ARB/XFER wait indefinitely, o_Timeout is tied low.
//
// Ports
//   i_Clk, i_Rst            clock, asynchronous active-high reset
//   i_AVIn_*  / o_AVIn_*    Avalon-MM slave side facing the master
//   o_Req, o_Lock, i_Gnt    per-slave arbiter handshake
//   o_AVOut_* / i_AVOut_*   per-slave Avalon-MM master side, flattened
//                           (slave k occupies slice k)
//   o_Timeout               one-cycle watchdog expiry pulse
//
// States
//   IDLE | no request; decode and launch a new access
//   ARB  | requesting the selected slave's arbiter
//   XFER | granted and locked; transfer forwarded to the slave
//   ERR  | one-cycle local completion with DECERR_DATA
module master_interconnect #(
  parameter int          NUM_SLAVES     = 2,
  parameter int          SEL_BITS       = 1,
  parameter int          ADDR_W         = 30,
  parameter int          DATA_W         = 32,
  parameter logic [31:0] DECERR_DATA    = 32'hDEADBEEF,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic [ADDR_W-1:0]              i_AVIn_Addr,
  input  logic [DATA_W/8-1:0]            i_AVIn_ByteEn,
  input  logic                           i_AVIn_Read,
  input  logic                           i_AVIn_Write,
  input  logic [DATA_W-1:0]              i_AVIn_WriteData,
  output logic [DATA_W-1:0]              o_AVIn_ReadData,
  output logic                           o_AVIn_WaitRequest,
  output logic [NUM_SLAVES-1:0]          o_Req,
  output logic [NUM_SLAVES-1:0]          o_Lock,
  input  logic [NUM_SLAVES-1:0]          i_Gnt,
  output logic [NUM_SLAVES*ADDR_W-1:0]   o_AVOut_Addr,
  output logic [NUM_SLAVES*DATA_W/8-1:0] o_AVOut_ByteEn,
  output logic [NUM_SLAVES-1:0]          o_AVOut_Read,
  output logic [NUM_SLAVES-1:0]          o_AVOut_Write,
  output logic [NUM_SLAVES*DATA_W-1:0]   o_AVOut_WriteData,
  input  logic [NUM_SLAVES*DATA_W-1:0]   i_AVOut_ReadData,
  input  logic [NUM_SLAVES-1:0]          i_AVOut_WaitRequest,
  output logic                           o_Timeout
);

  typedef enum logic [1:0] {IDLE, ARB, XFER, ERR} state_t;

  state_t              r_State;
  logic [SEL_BITS-1:0] r_Sel;

  logic [SEL_BITS-1:0] w_Sel;
  logic                w_Mapped;
  logic                w_Rd;
  logic                w_Wr;
  logic                w_Gnt;
  logic                w_SlvWait;
  logic [DATA_W-1:0]   w_SlvRdata;
  logic                w_MstWait;
  logic                w_Done;
  logic                w_TimeUp;

  function automatic logic [NUM_SLAVES-1:0] f_OneHot(input logic [SEL_BITS-1:0] s);
    logic [NUM_SLAVES-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      if (32'(s) == k) v[k] = 1'b1;
    return v;
  endfunction

  assign w_Sel    = i_AVIn_Addr[ADDR_W-1 -: SEL_BITS];
  assign w_Mapped = (32'(w_Sel) < NUM_SLAVES);
  // A simultaneous read and write is taken as a write only.
  assign w_Wr     = i_AVIn_Write;
  assign w_Rd     = i_AVIn_Read & ~i_AVIn_Write;

  // Pick the latched slave's handshake signals; the loop form keeps the
  // select safe for any NUM_SLAVES / SEL_BITS combination.
  always_comb begin
    w_Gnt      = 1'b0;
    w_SlvWait  = 1'b1;
    w_SlvRdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (32'(r_Sel) == k) begin
        w_Gnt      = i_Gnt[k];
        w_SlvWait  = i_AVOut_WaitRequest[k];
        w_SlvRdata = i_AVOut_ReadData[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_MstWait = w_SlvWait | ~w_Gnt;
  assign w_Done    = (r_State == XFER) && !w_MstWait;

  assign o_AVOut_Addr      = {NUM_SLAVES{i_AVIn_Addr}};
  assign o_AVOut_ByteEn    = {NUM_SLAVES{i_AVIn_ByteEn}};
  assign o_AVOut_WriteData = {NUM_SLAVES{i_AVIn_WriteData}};

  // Strobes follow the grant so a grant dropped mid-transfer stalls the slave.
  always_comb begin
    o_AVOut_Read  = '0;
    o_AVOut_Write = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if ((r_State == XFER) && (32'(r_Sel) == k)) begin
        o_AVOut_Read[k]  = w_Rd & i_Gnt[k];
        o_AVOut_Write[k] = w_Wr & i_Gnt[k];
      end
    end
  end

  always_comb begin
    o_AVIn_WaitRequest = 1'b1;
    o_AVIn_ReadData    = '0;
    case (r_State)
      XFER: begin
        o_AVIn_WaitRequest = w_MstWait;
        o_AVIn_ReadData    = w_SlvRdata;
      end
      ERR: begin
        o_AVIn_WaitRequest = 1'b0;
        o_AVIn_ReadData    = DATA_W'(DECERR_DATA);
      end
      default: ;
    endcase
  end

`ifdef MASTER_INTERCONNECT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_Count;
  logic             r_Timeout;

  // Down-counter preloaded while idle; terminal count 0 is the last cycle
  // of ARB/XFER before the watchdog fires.
  assign w_TimeUp  = (r_Count == '0);
  assign o_Timeout = r_Timeout;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Count   <= '0;
      r_Timeout <= 1'b0;
    end else begin
      // A completion on the expiry cycle takes priority over the pulse.
      r_Timeout <= w_TimeUp && ((r_State == ARB) || ((r_State == XFER) && !w_Done));
      if (r_State == IDLE)
        r_Count <= CNT_W'(TIMEOUT_CYCLES - 1);
      else if ((r_State == ARB) || (r_State == XFER))
        r_Count <= r_Count - 1'b1;
    end
  end
`else
  assign w_TimeUp  = 1'b0;
  assign o_Timeout = 1'b0;
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= IDLE;
      r_Sel   <= '0;
      o_Req   <= '0;
      o_Lock  <= '0;
    end else begin
      case (r_State)
        IDLE: begin
          if (w_Rd | w_Wr) begin
            r_Sel <= w_Sel;
            if (w_Mapped) begin
              r_State <= ARB;
              o_Req   <= f_OneHot(w_Sel);
            end else begin
              r_State <= ERR;
            end
          end
        end
        ARB: begin
          if (w_TimeUp) begin
            r_State <= ERR;
            o_Req   <= '0;
            o_Lock  <= '0;
          end else if (w_Gnt) begin
            r_State <= XFER;
            o_Lock  <= f_OneHot(r_Sel);
          end
        end
        XFER: begin
          if (w_Done || w_TimeUp) begin
            r_State <= w_Done ? IDLE : ERR;
            o_Req   <= '0;
            o_Lock  <= '0;
          end
        end
        ERR:     r_State <= IDLE;
        default: r_State <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_interconnect.sv
module tb_master_interconnect;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT 0: two slaves
  logic [29:0] addr;
  logic [3:0]  be;
  logic        rd, wr;
  logic [31:0] wdata, rdata;
  logic        waitr;
  logic [1:0]  req, lock, gnt, ord, owr, iwait;
  logic [59:0] oaddr;
  logic [7:0]  obe;
  logic [63:0] owdata, irdata;
  logic        tmo;

  // DUT 1: single slave, upper half of the address space unmapped
  logic [29:0] b_addr;
  logic [3:0]  b_be;
  logic        b_rd, b_wr;
  logic [31:0] b_wdata, b_rdata;
  logic        b_waitr;
  logic [0:0]  b_req, b_lock, b_gnt, b_ord, b_owr, b_iwait;
  logic [29:0] b_oaddr;
  logic [3:0]  b_obe;
  logic [31:0] b_owdata, b_irdata;
  logic        b_tmo;

  master_interconnect #(.NUM_SLAVES(2), .SEL_BITS(1), .TIMEOUT_CYCLES(8)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_AVIn_Addr(addr), .i_AVIn_ByteEn(be), .i_AVIn_Read(rd), .i_AVIn_Write(wr),
    .i_AVIn_WriteData(wdata), .o_AVIn_ReadData(rdata), .o_AVIn_WaitRequest(waitr),
    .o_Req(req), .o_Lock(lock), .i_Gnt(gnt),
    .o_AVOut_Addr(oaddr), .o_AVOut_ByteEn(obe), .o_AVOut_Read(ord), .o_AVOut_Write(owr),
    .o_AVOut_WriteData(owdata), .i_AVOut_ReadData(irdata), .i_AVOut_WaitRequest(iwait),
    .o_Timeout(tmo)
  );

  master_interconnect #(.NUM_SLAVES(1), .SEL_BITS(1), .TIMEOUT_CYCLES(8)) dut1 (
    .i_Clk(clk), .i_Rst(rst),
    .i_AVIn_Addr(b_addr), .i_AVIn_ByteEn(b_be), .i_AVIn_Read(b_rd), .i_AVIn_Write(b_wr),
    .i_AVIn_WriteData(b_wdata), .o_AVIn_ReadData(b_rdata), .o_AVIn_WaitRequest(b_waitr),
    .o_Req(b_req), .o_Lock(b_lock), .i_Gnt(b_gnt),
    .o_AVOut_Addr(b_oaddr), .o_AVOut_ByteEn(b_obe), .o_AVOut_Read(b_ord), .o_AVOut_Write(b_owr),
    .o_AVOut_WriteData(b_owdata), .i_AVOut_ReadData(b_irdata), .i_AVOut_WaitRequest(b_iwait),
    .o_Timeout(b_tmo)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: for reads the expected ReadData, for writes the write data
  // that must be on the broadcast bus at completion.
  typedef struct {
    logic [31:0] data;
    bit          is_read;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk) begin
    if (!rst && (rd || wr) && !waitr) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_completion", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.is_read) chk("sb_rdata", {32'd0, rdata}, {32'd0, e.data});
        else           chk("sb_wdata", {32'd0, owdata[31:0]}, {32'd0, e.data});
      end
    end
  end

  // Drives one access on DUT 0 and plays the arbiter and slave: grant after
  // gdly cycles of Req, slave stall for swait XFER cycles. Cycle 0 is the
  // cycle the master strobe first appears.
  task automatic run_xfer(input logic [29:0] a, input bit r, input bit w, input logic [31:0] d,
                          input int gdly, input int swait,
                          output int done_cyc, output int req_first, output int lock_first,
                          output int tmo_cyc, output bit stb_seen, output bit bad,
                          output bit req_done);
    int s;
    int rc;
    int gc;
    s = int'(a[29]);
    rc = 0; gc = 0;
    done_cyc = -1; req_first = -1; lock_first = -1; tmo_cyc = -1;
    stb_seen = 0; bad = 0; req_done = 0;
    @(posedge clk); #1;
    addr = a; rd = r; wr = w; wdata = d; be = 4'hF;
    for (int c = 0; c < 40; c++) begin
      gnt = '0;
      if (req[s]) begin
        if (rc >= gdly) gnt[s] = 1'b1;
        rc++;
      end
      iwait = 2'b11;
      iwait[s] = !(lock[s] && gc >= swait);
      if (lock[s] && gnt[s]) gc++;
      @(negedge clk);
      if (req[s] && req_first < 0)   req_first = c;
      if (lock[s] && lock_first < 0) lock_first = c;
      if (tmo && tmo_cyc < 0)        tmo_cyc = c;
      if (ord[s] || owr[s])          stb_seen = 1;
      if (req[1-s] || lock[1-s] || ord[1-s] || owr[1-s]) bad = 1;
      if (!waitr) begin
        done_cyc = c;
        req_done = req[s];
        break;
      end
      @(posedge clk); #1;
    end
    if (done_cyc < 0) chk("xfer_completion_bound", 64'd0, 64'd1);
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    rd = 0; wr = 0; gnt = '0; iwait = 2'b11;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int dc, rf, lf, tc;
    bit sb, bd, rq;
    rst = 1;
    addr = '0; be = 4'hF; rd = 0; wr = 0; wdata = '0;
    gnt = '0; iwait = 2'b11; irdata = {32'hCAFEF00D, 32'h11111111};
    b_addr = '0; b_be = 4'hF; b_rd = 0; b_wr = 0; b_wdata = '0;
    b_gnt = '0; b_iwait = 1'b1; b_irdata = 32'h12345678;
    #2;
    chk("rst_req",   {62'd0, req},  64'd0);
    chk("rst_lock",  {62'd0, lock}, 64'd0);
    chk("rst_strb",  {60'd0, ord, owr}, 64'd0);
    chk("rst_wait",  {63'd0, waitr}, 64'd1);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    chk("rst_tmo",   {63'd0, tmo}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 0;

    // Write to slave 0, grant immediately, slave stalls one cycle.
    sb_q.push_back('{data: 32'h1, is_read: 1'b0});
    run_xfer(30'h0, 0, 1, 32'h1, 0, 1, dc, rf, lf, tc, sb, bd, rq);
    chk("w0_done_cyc", 64'(dc), 64'd3);
    chk("w0_req_first", 64'(rf), 64'd1);
    chk("w0_lock_first", 64'(lf), 64'd2);
    chk("w0_strobe", {63'd0, sb}, 64'd1);
    chk("w0_foreign", {63'd0, bd}, 64'd0);
    idle_bus();
    @(negedge clk);
    chk("w0_req_after", {62'd0, req}, 64'd0);
    chk("w0_lock_after", {62'd0, lock}, 64'd0);

    // Read from slave 1 with the grant delayed three cycles.
    sb_q.push_back('{data: 32'hCAFEF00D, is_read: 1'b1});
    run_xfer(30'h20000000, 1, 0, 32'h0, 3, 0, dc, rf, lf, tc, sb, bd, rq);
    chk("r1_done_cyc", 64'(dc), 64'd5);
    chk("r1_req_first", 64'(rf), 64'd1);
    chk("r1_lock_first", 64'(lf), 64'd5);
    chk("r1_foreign", {63'd0, bd}, 64'd0);
    idle_bus();

    // Unmapped access on the single-slave instance.
    @(posedge clk); #1;
    b_addr = 30'h20000000; b_rd = 1;
    @(negedge clk);
    chk("um_wait_c0", {63'd0, b_waitr}, 64'd1);
    chk("um_req_c0", {63'd0, b_req}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("um_wait_c1", {63'd0, b_waitr}, 64'd0);
    chk("um_rdata", {32'd0, b_rdata}, 64'hDEADBEEF);
    chk("um_req_c1", {63'd0, b_req}, 64'd0);
    @(posedge clk); #1;
    b_rd = 0;
    @(negedge clk);
    chk("um_wait_after", {63'd0, b_waitr}, 64'd1);

    // Reset asserted mid-XFER, then a normal write.
    @(posedge clk); #1;
    addr = 30'h0; rd = 1; wr = 0; gnt = '0; iwait = 2'b11;
    @(posedge clk); #1;
    gnt = 2'b01;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rx_read_strobe", {62'd0, ord}, 64'd1);
    chk("rx_lock", {62'd0, lock}, 64'd1);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("rx_req", {62'd0, req}, 64'd0);
    chk("rx_lock_rst", {62'd0, lock}, 64'd0);
    chk("rx_strb", {60'd0, ord, owr}, 64'd0);
    chk("rx_wait", {63'd0, waitr}, 64'd1);
    #3;
    rst = 0; rd = 0; gnt = '0;
    sb_q.push_back('{data: 32'h55, is_read: 1'b0});
    run_xfer(30'h0, 0, 1, 32'h55, 0, 0, dc, rf, lf, tc, sb, bd, rq);
    chk("rx_post_done", 64'(dc), 64'd2);
    idle_bus();

    // Back-to-back writes, slave 0 then slave 1, master keeps Write high.
    sb_q.push_back('{data: 32'hA0A0A0A0, is_read: 1'b0});
    sb_q.push_back('{data: 32'hB1B1B1B1, is_read: 1'b0});
    run_xfer(30'h0, 0, 1, 32'hA0A0A0A0, 0, 0, dc, rf, lf, tc, sb, bd, rq);
    chk("bb0_done", 64'(dc), 64'd2);
    chk("bb0_foreign", {63'd0, bd}, 64'd0);
    run_xfer(30'h20000000, 0, 1, 32'hB1B1B1B1, 0, 0, dc, rf, lf, tc, sb, bd, rq);
    chk("bb1_done", 64'(dc), 64'd2);
    chk("bb1_req_first", 64'(rf), 64'd1);
    chk("bb1_lock_first", 64'(lf), 64'd2);
    chk("bb1_foreign", {63'd0, bd}, 64'd0);
    idle_bus();

`ifdef MASTER_INTERCONNECT_TIMEOUT_EN
    // Grant never arrives: watchdog finishes the read with DECERR_DATA.
    sb_q.push_back('{data: 32'hDEADBEEF, is_read: 1'b1});
    run_xfer(30'h0, 1, 0, 32'h0, 1000, 0, dc, rf, lf, tc, sb, bd, rq);
    chk("to_done_cyc", 64'(dc), 64'd9);
    chk("to_pulse_cyc", 64'(tc), 64'd9);
    chk("to_req_at_done", {63'd0, rq}, 64'd0);
    chk("to_lock_never", 64'(lf), 64'hFFFFFFFFFFFFFFFF);
    idle_bus();
    @(negedge clk);
    chk("to_pulse_end", {63'd0, tmo}, 64'd0);
`else
    // Grant never arrives: without the watchdog the access stalls forever.
    begin
      bit seen;
      seen = 0;
      @(posedge clk); #1;
      addr = 30'h0; rd = 1; gnt = '0;
      repeat (20) begin
        @(negedge clk);
        if (tmo) seen = 1;
      end
      chk("nt_no_pulse", {63'd0, seen}, 64'd0);
      chk("nt_stalled", {63'd0, waitr}, 64'd1);
      chk("nt_req_held", {62'd0, req}, 64'd1);
      rst = 1; rd = 0;
      @(negedge clk);
      rst = 0;
    end
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/master_interconnect.md
Name: master_interconnect

Overview:
- Master-side stage of XbarV1 that sits directly upstream of the per-slave SlaveInterconnect arbiters.
- Takes one Avalon-MM master port and decodes the slave index from the top address bits.
- Requests the target slave's arbiter (Req/Lock/Gnt) and forwards the transfer once granted. Returns ReadData and WaitRequest to the master.
- Unmapped addresses complete locally with an error pattern.

Parameters:
- NUM_SLAVES, 2, number of downstream SlaveInterconnect ports.
- SEL_BITS, 1, number of top address bits used as slave index.
- ADDR_W, 30, word address width.
- DATA_W, 32, data width. ByteEn width is DATA_W/8.
- DECERR_DATA, 32'hDEADBEEF, ReadData returned for unmapped or timed-out accesses.
- TIMEOUT_CYCLES, 256, watchdog limit, used only with the optional feature.

Ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  asynchronous, active-high reset.
- i_AVIn_Addr  in  ADDR_W  master address.
- i_AVIn_ByteEn  in  DATA_W/8  master byte enables.
- i_AVIn_Read  in  1  master read.
- i_AVIn_Write  in  1  master write.
- i_AVIn_WriteData  in  DATA_W  master write data.
- o_AVIn_ReadData  out  DATA_W  read data to master.
- o_AVIn_WaitRequest  out  1  stall to master.
- o_Req  out  NUM_SLAVES  per-slave arbiter request.
- o_Lock  out  NUM_SLAVES  per-slave lock; held for the whole transfer.
- i_Gnt  in  NUM_SLAVES  per-slave grant.
- o_AVOut_Addr  out  NUM_SLAVES*ADDR_W  flattened; slave k occupies slice k.
- o_AVOut_ByteEn  out  NUM_SLAVES*DATA_W/8  flattened.
- o_AVOut_Read  out  NUM_SLAVES  per-slave read.
- o_AVOut_Write  out  NUM_SLAVES  per-slave write.
- o_AVOut_WriteData  out  NUM_SLAVES*DATA_W  flattened.
- i_AVOut_ReadData  in  NUM_SLAVES*DATA_W  flattened.
- i_AVOut_WaitRequest  in  NUM_SLAVES  per-slave stall.
- o_Timeout  out  1  one-cycle pulse on watchdog expiry. Tied 0 without the optional feature.

Behaviour:
- Reset (async): state IDLE; r_Sel=0.
  - All o_Req, o_Lock, o_AVOut_Read and o_AVOut_Write = 0.
  - o_AVIn_WaitRequest = 1; o_AVIn_ReadData = 0; o_Timeout = 0.
- Decode: sel = i_AVIn_Addr[ADDR_W-1 -: SEL_BITS]. Unmapped when sel >= NUM_SLAVES. sel is latched into r_Sel on leaving IDLE.
- Addr, ByteEn and WriteData are broadcast to every slave slice. Only slice r_Sel gets Read/Write asserted.
- Write and Read both high: treated as a write; the read is ignored.
- FSM states:
  - IDLE: no Req.
    - Read|Write with a mapped address -> ARB.
    - Read|Write with an unmapped address -> ERR.
  - ARB: o_Req[r_Sel]=1 (registered).
    - i_Gnt[r_Sel]=1 -> XFER.
    - o_Lock[r_Sel] is set on the same edge.
  - XFER: o_Req[r_Sel]=1, o_Lock[r_Sel]=1.
    - o_AVOut_Read/Write[r_Sel] = i_AVIn_Read/Write & i_Gnt[r_Sel].
    - o_AVIn_WaitRequest = i_AVOut_WaitRequest[r_Sel] | ~i_Gnt[r_Sel].
    - o_AVIn_ReadData = i_AVOut_ReadData slice r_Sel (combinational).
    - When WaitRequest is low the transfer completes this cycle -> IDLE; Req and Lock drop at that edge.
  - ERR: o_AVIn_WaitRequest=0 and ReadData=DECERR_DATA for exactly one cycle -> IDLE. Writes are discarded.
- o_AVIn_WaitRequest is 1 in IDLE and ARB.
- Minimum latency: with Gnt returned in the same cycle as Req and slave WaitRequest low, the master sees WaitRequest high for 2 cycles and completes in the 3rd.
- Grant dropping mid-XFER: stay in XFER with slave strobes gated off and the master stalled. Resume when the grant returns.
- Back-to-back: Read/Write still high in IDLE after a completion starts a new transaction. Minimum one IDLE cycle between transfers, with no Req in that cycle.
- Reset during ARB/XFER: Req, Lock and strobes drop immediately; any in-flight transfer is abandoned.

Optional Feature:
- Macro: MASTER_INTERCONNECT_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ARB and counts each cycle in ARB/XFER.
  - On reaching TIMEOUT_CYCLES-1 without completion, the next edge drops Req/Lock/strobes, pulses o_Timeout and enters ERR, which returns DECERR_DATA with WaitRequest low for one cycle.
  - A completion in the same cycle as expiry wins: normal completion, no pulse.
- Undefined: no counter; ARB/XFER wait indefinitely; o_Timeout=0.

Test Plan:
- Write 32'h1 to addr 0; Gnt same cycle; slave WaitRequest 1 cycle.
  - Expect o_Req[0] high 1 cycle after the Write, o_Lock[0] the next cycle, o_AVOut_Write[0] asserted.
  - Master completes on the 4th cycle; o_Req/o_Lock back to 0 afterwards.
- Read from addr 30'h20000000 (slave 1) with Gnt delayed 3 cycles; slave returns 32'hCAFEF00D.
  - Expect only o_Req[1] high and o_AVOut_Read[0]=0 throughout.
  - Master receives 32'hCAFEF00D with WaitRequest low.
- NUM_SLAVES=1 with an access to addr 30'h20000000.
  - Expect no Req; WaitRequest low on the 2nd cycle; ReadData=32'hDEADBEEF.
- Assert i_Rst mid-XFER.
  - Expect o_Req, o_Lock and strobes at 0 asynchronously and o_AVIn_WaitRequest=1.
  - A write issued after reset completes normally.
- Two back-to-back writes (slave 0, then slave 1).
  - Expect one IDLE cycle between them and the Lock handed off cleanly with no overlap.
- With MASTER_INTERCONNECT_TIMEOUT_EN and TIMEOUT_CYCLES=8, Gnt held 0.
  - Expect an o_Timeout pulse, Req dropped, and DECERR_DATA returned 9 cycles after the request started.
